// File: rtl/imem_pkg.sv
// Shared types and widths for the instruction memory boot loader.
// PC_W defaults to 16.
package imem_pkg;

   localparam int unsigned INSTR_W     = 16;
   localparam int unsigned LOAD_BYTE_W = 8;

   localparam int unsigned PC_W_DEF = 16;

   typedef enum logic [3:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StDataLo,
      StDataHi,
      StSumLo,
      StSumHi,
      StRun,
      StErr
   } ldr_state_t;

   // States in which the loader consumes a stream byte.
   function automatic logic accepts_byte(ldr_state_t s);
      return s inside {StLenLo, StLenHi, StDataLo, StDataHi, StSumLo, StSumHi};
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: 2**ADDR_W x INSTR_W, synchronous write, asynchronous read.
module imem_ram
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [INSTR_W-1:0] rdata_o
);

   logic [INSTR_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Program RAM and byte-stream boot loader; holds the core until a program is resident.
// Define IMEM_CHECKSUM_EN to require a 16-bit sum trailer after the data words.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned PC_W   = PC_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   load_start_i,
   input  logic                   byte_valid_i,
   input  logic [LOAD_BYTE_W-1:0] byte_data_i,
   output logic                   byte_ready_o,
   input  logic [PC_W-1:0]        pc_i,
   output logic [INSTR_W-1:0]     instruction_o,
   output logic                   cpu_hold_o,
   output logic                   loaded_o,
   output logic                   load_err_o
);

   localparam int unsigned Depth = 1 << ADDR_W;
   localparam int unsigned CmpW  = (PC_W > 17) ? PC_W : 17;

   ldr_state_t                state_q, state_d;
   logic [15:0]               len_q, len_d;
   logic [15:0]               count_q, count_d;
   logic [LOAD_BYTE_W-1:0]    lo_q, lo_d;
   logic                      cpu_hold_q, cpu_hold_d;
   logic                      loaded_q, loaded_d;
   logic                      load_err_q, load_err_d;
`ifdef IMEM_CHECKSUM_EN
   logic [15:0]               sum_q, sum_d;
`endif

   logic                      xfer;
   logic [15:0]               word_in;
   logic                      len_bad;
   logic                      last_word;
   logic                      ram_we;
   logic [INSTR_W-1:0]        ram_rdata;

   assign byte_ready_o = accepts_byte(state_q) && !load_start_i;
   assign xfer         = byte_valid_i && byte_ready_o;
   assign word_in      = {byte_data_i, lo_q};
   assign len_bad      = (word_in == 16'd0) || ({1'b0, word_in} > 17'(Depth));
   assign last_word    = (count_q == len_q - 16'd1);

   // State register plus the registered status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cpu_hold_q <= 1'b1;
         loaded_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpu_hold_q <= cpu_hold_d;
         loaded_q   <= loaded_d;
         load_err_q <= load_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load_start_i) begin
         state_d = StLenLo;
      end else if (xfer) begin
         case (state_q)
            StLenLo:  state_d = StLenHi;
            StLenHi:  state_d = len_bad ? StErr : StDataLo;
            StDataLo: state_d = StDataHi;
`ifdef IMEM_CHECKSUM_EN
            StDataHi: state_d = last_word ? StSumLo : StDataLo;
            StSumLo:  state_d = StSumHi;
            StSumHi:  state_d = (word_in == sum_q) ? StRun : StErr;
`else
            StDataHi: state_d = last_word ? StRun : StDataLo;
`endif
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cpu_hold_d = (state_d != StRun);
      loaded_d   = (state_d == StRun);
      load_err_d = (state_d == StErr);
   end

   // Loader datapath: length, word counter, low-byte latch and RAM write.
   always_comb begin
      len_d   = len_q;
      count_d = count_q;
      lo_d    = lo_q;
      ram_we  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (load_start_i) begin
         len_d   = '0;
         count_d = '0;
      end else if (xfer) begin
         case (state_q)
            StLenLo, StDataLo, StSumLo: lo_d = byte_data_i;
            StLenHi: begin
               len_d   = len_bad ? 16'd0 : word_in;
               count_d = '0;
`ifdef IMEM_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
            StDataHi: begin
               ram_we  = 1'b1;
               count_d = count_q + 16'd1;
`ifdef IMEM_CHECKSUM_EN
               sum_d   = sum_q + word_in;
`endif
            end
            default: ;
         endcase
      end
      if (state_d == StErr) len_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q   <= '0;
         count_q <= '0;
         lo_q    <= '0;
`ifdef IMEM_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         len_q   <= len_d;
         count_q <= count_d;
         lo_q    <= lo_d;
`ifdef IMEM_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   imem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (count_q[ADDR_W-1:0]),
      .wdata_i (word_in),
      .raddr_i (pc_i[ADDR_W-1:0]),
      .rdata_o (ram_rdata)
   );

   // Full-width compare so pc bits above the RAM index also gate the read.
   assign instruction_o = (CmpW'(pc_i) < CmpW'(len_q)) ? ram_rdata : '0;

   assign cpu_hold_o = cpu_hold_q;
   assign loaded_o   = loaded_q;
   assign load_err_o = load_err_q;

endmodule
